// File: rtl/rv_mul_sequencer.sv
// rv_mul_sequencer: multi-cycle RISC-V MUL/MULH/MULHSU/MULHU unit.
// Works on operand magnitudes. One 16x16 unsigned multiplier is reused for the
// four partial products. A final cycle applies the sign and selects the word.

// Shared combinational unsigned 16x16 multiplier.
module Sixteen_bit_multiplier (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  assign p = {16'b0, a} * {16'b0, b};
endmodule

module rv_mul_sequencer #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_funct,
  input  logic [31:0]      in_op_a,
  input  logic [31:0]      in_op_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  // Everything captured at accept; magnitudes are unsigned from here on.
  typedef struct packed {
    logic [1:0]       funct;
    logic [TAG_W-1:0] tag;
    logic [31:0]      mag_a;
    logic [31:0]      mag_b;
    logic             neg;
  } req_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt;
  logic [63:0] acc;
  req_t        req_q, req_d;

  logic        accept;
  logic        a_signed, b_signed, sa, sb;
  logic [15:0] mul_a, mul_b;
  logic [31:0] pp;
  logic [63:0] pp_sh;
  logic [63:0] p_signed;

  assign in_ready = (state == IDLE) && !flush;
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  // Decode signedness and build magnitudes of the incoming request.
  always_comb begin
    a_signed    = (in_funct == 2'b01) || (in_funct == 2'b10);
    b_signed    = (in_funct == 2'b01);
    sa          = in_op_a[31] & a_signed;
    sb          = in_op_b[31] & b_signed;
    req_d.funct = in_funct;
    req_d.tag   = in_tag;
    req_d.mag_a = sa ? (~in_op_a + 32'd1) : in_op_a;
    req_d.mag_b = sb ? (~in_op_b + 32'd1) : in_op_b;
    req_d.neg   = sa ^ sb;
  end

  // Half selection: cnt[1] picks the high half of a, cnt[0] the high half of b.
  always_comb begin
    mul_a = req_q.mag_a[15:0];
    mul_b = req_q.mag_b[15:0];
    if (cnt[1]) mul_a = req_q.mag_a[31:16];
    if (cnt[0]) mul_b = req_q.mag_b[31:16];
  end

  Sixteen_bit_multiplier u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (pp)
  );

  // Place the partial product at its weight: 0, 16, 16, 32.
  always_comb begin
    pp_sh = {32'b0, pp};
    case (cnt)
      2'd0:    pp_sh = {32'b0, pp};
      2'd1,
      2'd2:    pp_sh = {16'b0, pp, 16'b0};
      default: pp_sh = {pp, 32'b0};
    endcase
  end

  assign p_signed = req_q.neg ? (~acc + 64'd1) : acc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush wins over every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)    state_nxt = CALC;
      CALC: if (cnt == 2'd3) state_nxt = SIGN;
      SIGN: state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Datapath: latch request, accumulate partial products, sign and publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 2'd0;
      acc        <= 64'd0;
      req_q      <= '0;
      out_valid  <= 1'b0;
      out_result <= 32'd0;
      out_tag    <= '0;
    end else if (flush) begin
      cnt       <= 2'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          req_q <= req_d;
          acc   <= 64'd0;
          cnt   <= 2'd0;
        end
        CALC: begin
          acc <= acc + pp_sh;
          cnt <= cnt + 2'd1;
        end
        SIGN: begin
          out_result <= (req_q.funct == 2'b00) ? p_signed[31:0] : p_signed[63:32];
          out_tag    <= req_q.tag;
          out_valid  <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mul_sequencer.sv
// Randomized self-checking bench for rv_mul_sequencer against a signed
// 66-bit arithmetic reference.
module tb_rv_mul_sequencer;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]       in_funct;
  logic [31:0]      in_op_a, in_op_b, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;

  int checks = 0;
  int failures = 0;

  rv_mul_sequencer #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_op_a(in_op_a), .in_op_b(in_op_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: extend each operand per funct, multiply as signed, pick the word.
  function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] ea, eb, prod;
    ea = (f == 2'b01 || f == 2'b10) ? {{34{a[31]}}, a} : {34'b0, a};
    eb = (f == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
    prod = ea * eb;
    return (f == 2'b00) ? prod[31:0] : prod[63:32];
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one op, check latency, apply backpressure, check result and release.
  task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t, input int stall);
    logic [31:0] exp_r;
    int n;
    exp_r = ref_mul(f, a, b);
    in_funct = f; in_op_a = a; in_op_b = b; in_tag = t; in_valid = 1'b1; out_ready = 1'b0;
    chk("in_ready_idle", in_ready, 1);
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      out_ready = 1'($urandom_range(0, 1));
      step(); n++;
    end
    chk("latency", n, 5);
    chk("result", out_result, exp_r);
    chk("tag", out_tag, t);
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1; in_op_a = $urandom; in_tag = ~t;
      chk("busy_in_ready", in_ready, 0);
      step();
      chk("stall_valid", out_valid, 1);
      chk("stall_result", out_result, exp_r);
      chk("stall_tag", out_tag, t);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("busy_after", busy, 0);
    chk("in_ready_after", in_ready, 1);
  endtask

  function automatic logic [31:0] pick_op();
    logic [31:0] corners [5];
    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFFFFFF;
    corners[3] = 32'h80000000; corners[4] = 32'h7FFFFFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct = 2'b00; in_op_a = '0; in_op_b = '0; in_tag = '0;
    #12; rst_n = 1'b1; #1;
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_tag", out_tag, 0);

    // Directed cases with hand-computed expectations.
    run_op(2'b00, 32'd7, 32'd6, 5'd3, 0);
    chk("mul_7x6", ref_mul(2'b00, 32'd7, 32'd6), 32'h2A);
    run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 0);
    chk("mulhu_ff", ref_mul(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 1);
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 0);
    run_op(2'b10, 32'hFFFFFFFF, 32'h2, 5'd7, 0);
    run_op(2'b01, 32'h80000000, 32'h80000000, 5'd8, 5);
    chk("mulh_min", ref_mul(2'b01, 32'h80000000, 32'h80000000), 32'h40000000);

    // Flush while in CALC with cnt==2.
    in_funct = 2'b11; in_op_a = 32'h1234; in_op_b = 32'h5678; in_tag = 5'd9; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    step(); step();
    chk("calc_busy", busy, 1);
    flush = 1'b1;
    chk("flush_in_ready", in_ready, 0);
    step(); flush = 1'b0;
    chk("flush_calc_busy", busy, 0);
    chk("flush_calc_valid", out_valid, 0);

    // Flush in DONE together with out_ready.
    in_funct = 2'b00; in_op_a = 32'd3; in_op_b = 32'd5; in_tag = 5'd10; in_valid = 1'b1;
    step(); in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("done_valid", out_valid, 1);
    flush = 1'b1; out_ready = 1'b1;
    step(); flush = 1'b0; out_ready = 1'b0;
    chk("flush_done_valid", out_valid, 0);
    chk("flush_done_busy", busy, 0);

    // Flush blocks an accept in IDLE.
    flush = 1'b1; in_valid = 1'b1;
    chk("flush_idle_ready", in_ready, 0);
    step(); flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_busy", busy, 0);

    // Async reset mid-operation.
    in_valid = 1'b1; step(); in_valid = 1'b0; step();
    rst_n = 1'b0; #1;
    chk("arst_busy", busy, 0);
    chk("arst_out_result", out_result, 0);
    #2; rst_n = 1'b1; step();

    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd11, 0);

    for (int i = 0; i < 2000; i++)
      run_op(2'($urandom_range(0, 3)), pick_op(), pick_op(), TAG_W'(i),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
